mini2_top: RTL and testbench

- Chip-level RGB LED colour-wheel driver for a 12 MHz iCE40 board.
- Sweeps the LED hue continuously through six 60° segments (R→Y→G→C→B→M→R), about once per second.
- Each channel is driven by its own PWM generator with a period of PWM_INTERVAL clocks.
- Outputs connect directly to the board's current-sink RGB LED pins.

---
 rtl/mini2_top.sv | 76 +++++++
 tb/tb_mini2_top.sv | 84 ++++++++
 2 files changed

// File: rtl/mini2_top.sv
// mini2_top: RGB colour-wheel LED driver, three PWM channels sweeping six hue segments.
// Define RGB_ACTIVE_HIGH_EN for active-high outputs (default active-low, current-sink pins).
module mini2_top #(
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEP_INTERVAL = 1667
) (
    input  logic clk,
    input  logic rst_n,
    output logic RGB_R,
    output logic RGB_G,
    output logic RGB_B
);
    localparam int PW = $clog2(PWM_INTERVAL + 1);
    localparam int SW = $clog2(STEP_INTERVAL + 1);
    localparam logic [PW-1:0] M  = PW'(PWM_INTERVAL);
    localparam logic [PW-1:0] M1 = PW'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] S1 = SW'(STEP_INTERVAL - 1);
`ifdef RGB_ACTIVE_HIGH_EN
    localparam logic OFF = 1'b0;
`else
    localparam logic OFF = 1'b1;
`endif

    logic [PW-1:0] pwm_cnt_q, pwm_cnt_d, ramp_q, ramp_d;
    logic [PW-1:0] duty_r, duty_g, duty_b;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [2:0]    seg_q, seg_d, on, rgb_q, rgb_d;
    logic          step;

    always_comb begin
        step       = step_cnt_q == S1;
        pwm_cnt_d  = pwm_cnt_q == M1 ? '0 : pwm_cnt_q + 1'b1;
        step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
        ramp_d     = step ? (ramp_q == M1 ? '0 : ramp_q + 1'b1) : ramp_q;
        // Illegal codes 6/7 fall back to seg 0 on the next step.
        seg_d      = !step           ? seg_q :
                     seg_q > 3'd5    ? 3'd0  :
                     ramp_q != M1    ? seg_q :
                     seg_q == 3'd5   ? 3'd0  : seg_q + 3'd1;
        duty_r = M;
        duty_g = ramp_q;
        duty_b = '0;
        case (seg_q)
            3'd1: begin duty_r = M - ramp_q; duty_g = M;          duty_b = '0;     end
            3'd2: begin duty_r = '0;         duty_g = M;          duty_b = ramp_q; end
            3'd3: begin duty_r = '0;         duty_g = M - ramp_q; duty_b = M;      end
            3'd4: begin duty_r = ramp_q;     duty_g = '0;         duty_b = M;      end
            3'd5: begin duty_r = M;          duty_g = '0;         duty_b = M - ramp_q; end
            default: ;
        endcase
        on = {pwm_cnt_q < duty_r, pwm_cnt_q < duty_g, pwm_cnt_q < duty_b};
`ifdef RGB_ACTIVE_HIGH_EN
        rgb_d = on;
`else
        rgb_d = ~on;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            ramp_q     <= '0;
            seg_q      <= '0;
            rgb_q      <= {3{OFF}};
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            ramp_q     <= ramp_d;
            seg_q      <= seg_d;
            rgb_q      <= rgb_d;
        end
    end

    assign {RGB_R, RGB_G, RGB_B} = rgb_q;
endmodule

// File: tb/tb_mini2_top.sv
// tb_mini2_top: scoreboard bench for mini2_top with PWM_INTERVAL=10, STEP_INTERVAL=2.
module tb_mini2_top;
    localparam int M = 10;
    localparam int S = 2;
`ifdef RGB_ACTIVE_HIGH_EN
    localparam logic [2:0] OFF = 3'b000;
    localparam bit         AH  = 1'b1;
`else
    localparam logic [2:0] OFF = 3'b111;
    localparam bit         AH  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RGB_R, RGB_G, RGB_B;
    int n_chk = 0;
    int n_fail = 0;
    int t = 0;
    logic [2:0] sb_q[$];

    mini2_top #(.PWM_INTERVAL(M), .STEP_INTERVAL(S)) dut (
        .clk(clk), .rst_n(rst_n), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    // Expected pins after the edge that samples state t cycles past reset release.
    function automatic logic [2:0] exp_rgb(input int tc);
        int pwm, st, r, sg, dr, dg, db;
        logic [2:0] on;
        pwm = tc % M;
        st  = tc / S;
        r   = st % M;
        sg  = (st / M) % 6;
        case (sg)
            0: begin dr = M;     dg = r;     db = 0;     end
            1: begin dr = M - r; dg = M;     db = 0;     end
            2: begin dr = 0;     dg = M;     db = r;     end
            3: begin dr = 0;     dg = M - r; db = M;     end
            4: begin dr = r;     dg = 0;     db = M;     end
            default: begin dr = M; dg = 0;   db = M - r; end
        endcase
        on = {pwm < dr, pwm < dg, pwm < db};
        return AH ? on : ~on;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            sb_q.push_back(exp_rgb(t));
            t++;
        end
        @(negedge clk);
        if (sb_q.size() > 0) check("rgb", {RGB_R, RGB_G, RGB_B}, sb_q.pop_front());
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset", {RGB_R, RGB_G, RGB_B}, OFF);
        rst_n = 1'b1;
        tick();
        check("first", {RGB_R, RGB_G, RGB_B}, AH ? 3'b100 : 3'b011);
        repeat (299) tick();
        while ((t % 120) != 65) tick();
        #2 rst_n = 1'b0;
        #1 check("async", {RGB_R, RGB_G, RGB_B}, OFF);
        t = 0;
        sb_q.delete();
        repeat (3) tick();
        check("held", {RGB_R, RGB_G, RGB_B}, OFF);
        rst_n = 1'b1;
        repeat (250) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
